// File: rtl/execute_stage_if.sv
// Bus between the ID/EX register, the hazard unit, writeback and the execute stage.
// The master side drives the ID/EX operands and controls. The slave side is the execute stage.
interface execute_stage_if #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
);
    logic [WIDTH-1:0] RnE;
    logic [WIDTH-1:0] RmE;
    logic [WIDTH-1:0] ImmExtE5;
    logic [WIDTH-1:0] ImmExtE8;
    logic [RW-1:0]    RnNumE;
    logic [RW-1:0]    RmNumE;
    logic [RW-1:0]    RdNumE;
    logic [1:0]       ALUopE;
    logic [1:0]       shiftE;
    logic             writeE;
    logic             aselE;
    logic [1:0]       bselE;
    logic             flagsE;
    logic [WIDTH-1:0] ResultW;
    logic [RW-1:0]    RdNumW;
    logic             writeW;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] ResultM;
    logic [WIDTH-1:0] StoreDataM;
    logic [RW-1:0]    RdNumM;
    logic             writeM;
    logic             Z;
    logic             N;
    logic             V;

    modport master (
        output RnE, RmE, ImmExtE5, ImmExtE8,
        output RnNumE, RmNumE, RdNumE,
        output ALUopE, shiftE, writeE, aselE, bselE, flagsE,
        output ResultW, RdNumW, writeW,
        output stall, flush,
        input  ResultM, StoreDataM, RdNumM, writeM, Z, N, V
    );

    modport slave (
        input  RnE, RmE, ImmExtE5, ImmExtE8,
        input  RnNumE, RmNumE, RdNumE,
        input  ALUopE, shiftE, writeE, aselE, bselE, flagsE,
        input  ResultW, RdNumW, writeW,
        input  stall, flush,
        output ResultM, StoreDataM, RdNumM, writeM, Z, N, V
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipeline: forwarding, barrel shift, operand select, ALU,
// the EX/MEM pipeline register and the Z/N/V status register.
module execute_stage #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
) (
    input logic            clk,
    input logic            reset,
    execute_stage_if.slave bus
);
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    localparam logic [1:0] BSEL_RM   = 2'b00;
    localparam logic [1:0] BSEL_IMM5 = 2'b01;
    localparam logic [1:0] BSEL_IMM8 = 2'b10;
    localparam logic [1:0] BSEL_ZERO = 2'b11;

    logic [WIDTH-1:0] resultQ, resultD;
    logic [WIDTH-1:0] storeDataQ, storeDataD;
    logic [RW-1:0]    rdNumQ, rdNumD;
    logic             writeQ, writeD;
    logic             zQ, zD;
    logic             nQ, nD;
    logic             vQ, vD;

    logic [WIDTH-1:0] fwdRn;
    logic [WIDTH-1:0] fwdRm;
    logic [WIDTH-1:0] shiftedRm;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluResult;
    logic             aluZ;
    logic             aluN;
    logic             aluV;

    // The registered EX/MEM slot beats writeback; a bubble (writeQ=0) never matches.
    always_comb begin
        fwdRn = bus.RnE;
        if (writeQ && (rdNumQ == bus.RnNumE)) begin
            fwdRn = resultQ;
        end else if (bus.writeW && (bus.RdNumW == bus.RnNumE)) begin
            fwdRn = bus.ResultW;
        end

        fwdRm = bus.RmE;
        if (writeQ && (rdNumQ == bus.RmNumE)) begin
            fwdRm = resultQ;
        end else if (bus.writeW && (bus.RdNumW == bus.RmNumE)) begin
            fwdRm = bus.ResultW;
        end
    end

    always_comb begin
        shiftedRm = fwdRm;
        case (bus.shiftE)
            SH_NONE: shiftedRm = fwdRm;
            SH_LSL1: shiftedRm = {fwdRm[WIDTH-2:0], 1'b0};
            SH_LSR1: shiftedRm = {1'b0, fwdRm[WIDTH-1:1]};
            SH_ASR1: shiftedRm = {fwdRm[WIDTH-1], fwdRm[WIDTH-1:1]};
            default: shiftedRm = fwdRm;
        endcase
    end

    always_comb begin
        opA = bus.aselE ? '0 : fwdRn;
        opB = shiftedRm;
        case (bus.bselE)
            BSEL_RM:   opB = shiftedRm;
            BSEL_IMM5: opB = bus.ImmExtE5;
            BSEL_IMM8: opB = bus.ImmExtE8;
            BSEL_ZERO: opB = '0;
            default:   opB = shiftedRm;
        endcase
    end

    always_comb begin
        aluResult = '0;
        aluV      = 1'b0;
        case (bus.ALUopE)
            ALU_ADD: begin
                aluResult = opA + opB;
                aluV      = (opA[WIDTH-1] == opB[WIDTH-1]) &&
                            (aluResult[WIDTH-1] != opA[WIDTH-1]);
            end
            ALU_SUB: begin
                aluResult = opA - opB;
                aluV      = (opA[WIDTH-1] != opB[WIDTH-1]) &&
                            (aluResult[WIDTH-1] != opA[WIDTH-1]);
            end
            ALU_AND: aluResult = opA & opB;
            ALU_NOT: aluResult = ~opB;
            default: aluResult = '0;
        endcase
        aluZ = (aluResult == '0);
        aluN = aluResult[WIDTH-1];
    end

    // Flush beats stall; flags only move on a real load of a flag-setting instruction.
    always_comb begin
        resultD    = resultQ;
        storeDataD = storeDataQ;
        rdNumD     = rdNumQ;
        writeD     = writeQ;
        zD         = zQ;
        nD         = nQ;
        vD         = vQ;
        if (bus.flush) begin
            resultD    = '0;
            storeDataD = '0;
            rdNumD     = '0;
            writeD     = 1'b0;
        end else if (!bus.stall) begin
            resultD    = aluResult;
            storeDataD = fwdRm;
            rdNumD     = bus.RdNumE;
            writeD     = bus.writeE;
            if (bus.flagsE) begin
                zD = aluZ;
                nD = aluN;
                vD = aluV;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resultQ    <= '0;
            storeDataQ <= '0;
            rdNumQ     <= '0;
            writeQ     <= 1'b0;
            zQ         <= 1'b0;
            nQ         <= 1'b0;
            vQ         <= 1'b0;
        end else begin
            resultQ    <= resultD;
            storeDataQ <= storeDataD;
            rdNumQ     <= rdNumD;
            writeQ     <= writeD;
            zQ         <= zD;
            nQ         <= nD;
            vQ         <= vD;
        end
    end

    assign bus.ResultM    = resultQ;
    assign bus.StoreDataM = storeDataQ;
    assign bus.RdNumM     = rdNumQ;
    assign bus.writeM     = writeQ;
    assign bus.Z          = zQ;
    assign bus.N          = nQ;
    assign bus.V          = vQ;
endmodule
